// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg : controller state encoding and byte-lane offset constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`ifndef DMEM_DEFINES_SV
`include "defines.sv"
`endif

package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RMW_RD = 2'd2,
      ST_RMW_WR = 2'd3
   } dmem_state_t;

   localparam int unsigned c_lane_b0_lsb = 0;
   localparam int unsigned c_lane_b1_lsb = 8;
   localparam int unsigned c_lane_b2_lsb = 16;
   localparam int unsigned c_lane_b3_lsb = 24;
   localparam int unsigned c_lane_h0_lsb = 0;
   localparam int unsigned c_lane_h1_lsb = 16;

   // Halfwords are located by addr[1] only; addr[0] is ignored for them.
   function automatic int unsigned lane_lsb(input logic half, input logic [1:0] off);
      int unsigned lsb;
      lsb = c_lane_b0_lsb;
      if (half) begin
         lsb = off[1] ? c_lane_h1_lsb : c_lane_h0_lsb;
      end else begin
         case (off)
            2'd0:    lsb = c_lane_b0_lsb;
            2'd1:    lsb = c_lane_b1_lsb;
            2'd2:    lsb = c_lane_b2_lsb;
            default: lsb = c_lane_b3_lsb;
         endcase
      end
      return lsb;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_ctrl_if : MEM-stage request/response bundle between pipeline and controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`ifndef DMEM_DEFINES_SV
`include "defines.sv"
`endif

interface dmem_ctrl_if;

   logic                        req_valid;
   logic                        mem_read;
   logic                        mem_write;
   logic [`MEM_ADDR_WIDTH-1:0]  addr;
   logic [`REG_DATA_WIDTH-1:0]  wr_data;
   logic [`MASK_WIDTH-1:0]      mask;
   logic                        unsigned_load;
   logic                        stall;
   logic                        done;
   logic [`REG_DATA_WIDTH-1:0]  rd_data;

   modport master (
      output req_valid, mem_read, mem_write, addr, wr_data, mask, unsigned_load,
      input  stall, done, rd_data
   );

   modport slave (
      input  req_valid, mem_read, mem_write, addr, wr_data, mask, unsigned_load,
      output stall, done, rd_data
   );

endinterface

`default_nettype wire

// File: rtl/defines.sv
// ----------------------------------------------------------------------------
// defines.sv : shared width and access-mask macros for the data-memory path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`ifndef DMEM_DEFINES_SV
`define DMEM_DEFINES_SV

`define MEM_ADDR_WIDTH 32
`define REG_DATA_WIDTH 32
`define MASK_WIDTH     2

`define MASK_B 2'b00
`define MASK_H 2'b01
`define MASK_W 2'b10

`endif
`default_nettype wire

// File: rtl/dmem_lane_merge.sv
// ----------------------------------------------------------------------------
// dmem_lane_merge : combinational sub-word insert (stores) and extract/extend (loads)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`ifndef DMEM_DEFINES_SV
`include "defines.sv"
`endif

module dmem_lane_merge
   import dmem_pkg::*;
(
   input  logic [`REG_DATA_WIDTH-1:0] rd_word,
   input  logic [`REG_DATA_WIDTH-1:0] wr_data,
   input  logic [`MASK_WIDTH-1:0]     mask,
   input  logic [1:0]                 byte_off,
   input  logic                       unsigned_load,
   output logic [`REG_DATA_WIDTH-1:0] merged,
   output logic [`REG_DATA_WIDTH-1:0] extracted
);

   localparam int unsigned c_dw = `REG_DATA_WIDTH;
   localparam logic [c_dw-1:0] c_byte_ones = c_dw'(8'hFF);
   localparam logic [c_dw-1:0] c_half_ones = c_dw'(16'hFFFF);

   logic              w_is_byte;
   logic              w_is_half;
   int unsigned       w_lsb;
   logic [c_dw-1:0]   w_lane;

   always_comb begin
      w_is_byte = (mask == `MASK_B);
      w_is_half = (mask == `MASK_H);
      w_lsb     = lane_lsb(w_is_half, byte_off);
      w_lane    = rd_word >> w_lsb;
      merged    = rd_word;
      extracted = rd_word;
      if (w_is_byte) begin
         merged    = (rd_word & ~(c_byte_ones << w_lsb)) | (c_dw'(wr_data[7:0]) << w_lsb);
         extracted = unsigned_load ? c_dw'(w_lane[7:0])
                                   : {{(c_dw-8){w_lane[7]}}, w_lane[7:0]};
      end else if (w_is_half) begin
         merged    = (rd_word & ~(c_half_ones << w_lsb)) | (c_dw'(wr_data[15:0]) << w_lsb);
         extracted = unsigned_load ? c_dw'(w_lane[15:0])
                                   : {{(c_dw-16){w_lane[15]}}, w_lane[15:0]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_ctrl : MEM-stage data-memory controller over a byte-mask-less BRAM port.
// Optional DMEM_MISALIGN_CHECK_EN adds a misalign output. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`ifndef DMEM_DEFINES_SV
`include "defines.sv"
`endif

module dmem_ctrl
   import dmem_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   dmem_ctrl_if.slave                 bus,
   output logic [`MEM_ADDR_WIDTH-1:0] dmem_addr,
   output logic [`REG_DATA_WIDTH-1:0] dmem_wr_data,
   output logic                       dmem_wr_en,
   output logic                       dmem_rd_en,
   input  logic [`REG_DATA_WIDTH-1:0] dmem_rd_data,
`ifdef DMEM_MISALIGN_CHECK_EN
   output logic                       misalign,
`endif
   output logic [31:0]                stall_cnt
);

   dmem_state_t                 r_state;
   logic [`REG_DATA_WIDTH-1:0]  r_merge;
   logic [31:0]                 r_stall_cnt;

   logic                        w_access;
   logic                        w_word;
   logic                        w_misalign;
   logic                        w_stall;
   logic                        w_done;
   logic                        w_rd_en;
   logic                        w_wr_en;
   logic [`REG_DATA_WIDTH-1:0]  w_rd_data;
   logic [`REG_DATA_WIDTH-1:0]  w_merged;
   logic [`REG_DATA_WIDTH-1:0]  w_extracted;

   assign w_access = bus.req_valid && (bus.mem_read || bus.mem_write);
   assign w_word   = (bus.mask != `MASK_B) && (bus.mask != `MASK_H);

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_misalign = (r_state == ST_IDLE) && w_access &&
                       (((bus.mask == `MASK_H) && bus.addr[0]) ||
                        (w_word && (bus.addr[1:0] != 2'b00)));
   assign misalign   = w_misalign && !rst;
`else
   assign w_misalign = 1'b0;
`endif

   dmem_lane_merge u_lane_merge (
      .rd_word       (dmem_rd_data),
      .wr_data       (bus.wr_data),
      .mask          (bus.mask),
      .byte_off      (bus.addr[1:0]),
      .unsigned_load (bus.unsigned_load),
      .merged        (w_merged),
      .extracted     (w_extracted)
   );

   // Strobes depend on the live request so a word store finishes in its
   // arrival cycle; reset forces every strobe low so an abandoned RMW never writes.
   always_comb begin
      w_stall   = 1'b0;
      w_done    = 1'b0;
      w_rd_en   = 1'b0;
      w_wr_en   = 1'b0;
      w_rd_data = '0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (w_misalign) begin
                  w_done = 1'b1;
               end else if (w_access) begin
                  if (bus.mem_write && w_word) begin
                     w_wr_en = 1'b1;
                     w_done  = 1'b1;
                  end else begin
                     w_rd_en = 1'b1;
                     w_stall = 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               w_done    = 1'b1;
               w_rd_data = w_extracted;
            end
            ST_RMW_RD: w_stall = 1'b1;
            ST_RMW_WR: begin
               w_wr_en = 1'b1;
               w_done  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_merge     <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_access && !w_misalign) begin
                  if (!bus.mem_write) begin
                     r_state <= ST_LOAD;
                  end else if (!w_word) begin
                     r_state <= ST_RMW_RD;
                  end
               end
            end
            ST_LOAD:   r_state <= ST_IDLE;
            ST_RMW_RD: begin
               r_merge <= w_merged;
               r_state <= ST_RMW_WR;
            end
            ST_RMW_WR: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign dmem_addr    = {bus.addr[`MEM_ADDR_WIDTH-1:2], 2'b00};
   assign dmem_wr_data = (r_state == ST_RMW_WR) ? r_merge : bus.wr_data;
   assign dmem_wr_en   = w_wr_en;
   assign dmem_rd_en   = w_rd_en;
   assign stall_cnt    = r_stall_cnt;
   assign bus.stall    = w_stall;
   assign bus.done     = w_done;
   assign bus.rd_data  = w_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_ctrl : scoreboard bench for dmem_ctrl with a BRAM model and byte-array
// reference memory. Exercises misalign when DMEM_MISALIGN_CHECK_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`ifndef DMEM_DEFINES_SV
`include "defines.sv"
`endif

module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_clr = 1'b1;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wr_data;
   logic [31:0] dmem_rd_data;
   logic [31:0] stall_cnt;
   logic        dmem_wr_en;
   logic        dmem_rd_en;
`ifdef DMEM_MISALIGN_CHECK_EN
   logic        misalign;
`endif

   always #5 clk = ~clk;

   dmem_ctrl_if bus ();

   dmem_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .dmem_addr    (dmem_addr),
      .dmem_wr_data (dmem_wr_data),
      .dmem_wr_en   (dmem_wr_en),
      .dmem_rd_en   (dmem_rd_en),
      .dmem_rd_data (dmem_rd_data),
`ifdef DMEM_MISALIGN_CHECK_EN
      .misalign     (misalign),
`endif
      .stall_cnt    (stall_cnt)
   );

   // Synchronous-read BRAM, 64 words
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else begin
         if (dmem_wr_en) mem[dmem_addr[7:2]] <= dmem_wr_data;
         if (dmem_rd_en) dmem_rd_data <= mem[dmem_addr[7:2]];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       tag;
      bit          is_load;
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  ref_b [0:255];
   int          checks_cnt = 0;
   int          errors_cnt = 0;
   int          exp_stall  = 0;
   int          g_start, g_done;
   logic [31:0] last_rd, last_wr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [7:0] a);
      logic [7:0] b;
      b = {a[7:2], 2'b00};
      return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
   endfunction

   function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] m, input bit uns);
      logic [7:0]  v;
      logic [15:0] h;
      case (m)
         `MASK_B: begin
            v = ref_b[a];
            return uns ? {24'b0, v} : {{24{v[7]}}, v};
         end
         `MASK_H: begin
            h = {ref_b[{a[7:1], 1'b1}], ref_b[{a[7:1], 1'b0}]};
            return uns ? {16'b0, h} : {{16{h[15]}}, h};
         end
         default: return model_word(a);
      endcase
   endfunction

   task automatic model_store(input logic [7:0] a, input logic [31:0] d, input logic [1:0] m);
      case (m)
         `MASK_B: ref_b[a] = d[7:0];
         `MASK_H: begin
            ref_b[{a[7:1], 1'b0}] = d[7:0];
            ref_b[{a[7:1], 1'b1}] = d[15:8];
         end
         default: begin
            for (int k = 0; k < 4; k++) ref_b[{a[7:2], 2'(k)}] = d[8*k +: 8];
         end
      endcase
   endtask

   task automatic issue(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] m, input bit uns);
      exp_t e, got_e;
      int   n, stalls;
      bit   wr_seen, fin;
      e.tag     = tag;
      e.is_load = rd && !wr;
      e.lat     = e.is_load ? 2 : ((m == `MASK_B || m == `MASK_H) ? 3 : 1);
      if (e.is_load) begin
         e.data = model_load(a[7:0], m, uns);
      end else begin
         model_store(a[7:0], d, m);
         e.data = model_word(a[7:0]);
      end
      sb.push_back(e);
      bus.req_valid = 1'b1; bus.mem_read = rd; bus.mem_write = wr;
      bus.addr = a; bus.wr_data = d; bus.mask = m; bus.unsigned_load = uns;
      n = 0; stalls = 0; wr_seen = 0; fin = 0;
      while (!fin) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            g_start = cyc;
            check_eq({tag, ".issue"}, 32'(dmem_rd_en | dmem_wr_en), 32'd1);
         end
         check_eq({tag, ".excl"}, 32'(dmem_rd_en & dmem_wr_en), 32'd0);
         if (bus.stall) stalls++;
         if (dmem_wr_en) begin
            wr_seen = 1;
            last_wr = dmem_wr_data;
            check_eq({tag, ".waddr"}, dmem_addr, {a[31:2], 2'b00});
         end
         if (bus.done) begin
            fin    = 1;
            g_done = cyc;
            got_e  = sb.pop_front();
            check_eq({got_e.tag, ".lat"}, n, got_e.lat);
            check_eq({got_e.tag, ".stall"}, stalls, got_e.lat - 1);
            if (got_e.is_load) begin
               last_rd = bus.rd_data;
               check_eq({got_e.tag, ".rdata"}, bus.rd_data, got_e.data);
            end else begin
               check_eq({got_e.tag, ".wen"}, 32'(wr_seen), 32'd1);
               check_eq({got_e.tag, ".wdata"}, last_wr, got_e.data);
            end
         end else if (n >= 8) begin
            fin = 1;
            check_eq({tag, ".timeout"}, n, e.lat);
            void'(sb.pop_front());
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      exp_stall += e.lat - 1;
   endtask

   initial begin
      int          sh_done;
      int          op;
      logic [31:0] ra;
      for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
      bus.req_valid = 0; bus.mem_read = 0; bus.mem_write = 0;
      bus.addr = '0; bus.wr_data = '0; bus.mask = `MASK_W; bus.unsigned_load = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst.stall",   32'(bus.stall),  32'd0);
      check_eq("rst.done",    32'(bus.done),   32'd0);
      check_eq("rst.rd_en",   32'(dmem_rd_en), 32'd0);
      check_eq("rst.wr_en",   32'(dmem_wr_en), 32'd0);
      check_eq("rst.rd_data", bus.rd_data,     32'd0);
      check_eq("rst.cnt",     stall_cnt,       32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_clr = 1'b0;
      @(posedge clk); #1;

      // Word stores, one issued with read and write both set
      issue("sw10", 0, 1, 32'h10, 32'h11223344, `MASK_W, 0);
      issue("sw20", 1, 1, 32'h20, 32'hAABBCCDD, `MASK_W, 0);
      issue("sw30", 0, 1, 32'h30, 32'hDEADBEEF, `MASK_W, 0);
      check_eq("sw30.const", last_wr, 32'hDEADBEEF);

      issue("lb13", 1, 0, 32'h13, 0, `MASK_B, 0);
      check_eq("lb13.const", last_rd, 32'h00000011);
      issue("lh12u", 1, 0, 32'h12, 0, `MASK_H, 1);
      check_eq("lh12u.const", last_rd, 32'h00001122);

      issue("sb21", 0, 1, 32'h21, 32'h0000005A, `MASK_B, 0);
      check_eq("sb21.const", last_wr, 32'hAABB5ADD);

      issue("lb20s", 1, 0, 32'h20, 0, `MASK_B, 0);
      check_eq("lb20s.const", last_rd, 32'hFFFFFFDD);
      issue("lh22s", 1, 0, 32'h22, 0, `MASK_H, 0);
      check_eq("lh22s.const", last_rd, 32'hFFFFAABB);
      issue("lw30", 1, 0, 32'h30, 0, `MASK_W, 0);

      // Sub-word store immediately followed by a load of the same word
      issue("sh40", 0, 1, 32'h40, 32'h1234BEEF, `MASK_H, 0);
      sh_done = g_done;
      issue("lw40", 1, 0, 32'h40, 0, `MASK_W, 0);
      check_eq("b2b.gap", g_start - sh_done, 32'd1);
      check_eq("lw40.const", last_rd, 32'h0000BEEF);

      // NOP request: valid with neither read nor write
      bus.req_valid = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.addr = 32'h44;
      repeat (3) begin
         @(negedge clk);
         check_eq("nop.done",   32'(bus.done), 32'd0);
         check_eq("nop.strobe", 32'(dmem_rd_en | dmem_wr_en), 32'd0);
         check_eq("nop.stall",  32'(bus.stall), 32'd0);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;

      for (int i = 0; i < 16; i++) begin
         op = int'($urandom_range(0, 5));
         ra = 32'h80 + 32'($urandom_range(0, 63));
         case (op)
            0: issue("rnd.sb", 0, 1, ra, $urandom, `MASK_B, 0);
            1: issue("rnd.sh", 0, 1, ra & ~32'h1, $urandom, `MASK_H, 0);
            2: issue("rnd.sw", 0, 1, ra & ~32'h3, $urandom, `MASK_W, 0);
            3: issue("rnd.lb", 1, 0, ra, 0, `MASK_B, 1'($urandom_range(0, 1)));
            4: issue("rnd.lh", 1, 0, ra & ~32'h1, 0, `MASK_H, 1'($urandom_range(0, 1)));
            default: issue("rnd.lw", 1, 0, ra & ~32'h3, 0, `MASK_W, 0);
         endcase
      end

      @(negedge clk);
      check_eq("stall_cnt", stall_cnt, exp_stall);
      @(posedge clk); #1;

      // Reset while the RMW read is outstanding
      bus.req_valid = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
      bus.addr = 32'h21; bus.wr_data = 32'h77; bus.mask = `MASK_B;
      @(negedge clk);
      check_eq("rmwrst.rd_en", 32'(dmem_rd_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rmwrst.wr_en0", 32'(dmem_wr_en), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.req_valid = 1'b0; bus.mem_write = 1'b0;
      @(negedge clk);
      check_eq("rmwrst.wr_en1", 32'(dmem_wr_en), 32'd0);
      check_eq("rmwrst.stall",  32'(bus.stall),  32'd0);
      check_eq("rmwrst.done",   32'(bus.done),   32'd0);
      check_eq("rmwrst.cnt",    stall_cnt,       32'd0);
      exp_stall = 0;
      @(posedge clk); #1;
      issue("lw20post", 1, 0, 32'h20, 0, `MASK_W, 0);
      check_eq("lw20post.const", last_rd, 32'hAABB5ADD);

`ifdef DMEM_MISALIGN_CHECK_EN
      bus.req_valid = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
      bus.addr = 32'h41; bus.mask = `MASK_W;
      @(negedge clk);
      check_eq("mis.flag",   32'(misalign), 32'd1);
      check_eq("mis.done",   32'(bus.done), 32'd1);
      check_eq("mis.strobe", 32'(dmem_rd_en | dmem_wr_en), 32'd0);
      check_eq("mis.stall",  32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.mem_read = 1'b0;
`endif

      @(negedge clk);
      check_eq("stall_cnt.end", stall_cnt, exp_stall);
      check_eq("sb.empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
